// File: rtl/mi_iq_2.sv
// Dual-issue instruction queue between fetch and the two decode slots.
// Circular storage of {inst, pc}. Up to two entries are accepted and up to
// two are retired per cycle. Flushes on redirect.
module mi_iq_2 #(
    parameter int unsigned INST_DW = 32,
    parameter int unsigned INST_AW = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned PTR_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               in_vld0_i,
    input  logic [INST_DW-1:0] in_inst0_i,
    input  logic [INST_AW-1:0] in_pc0_i,
    input  logic               in_vld1_i,
    input  logic [INST_DW-1:0] in_inst1_i,
    input  logic [INST_AW-1:0] in_pc1_i,
    output logic               in_rdy_o,
    output logic               out_vld0_o,
    output logic [INST_DW-1:0] out_inst0_o,
    output logic [INST_AW-1:0] out_pc0_o,
    output logic               out_vld1_o,
    output logic [INST_DW-1:0] out_inst1_o,
    output logic [INST_AW-1:0] out_pc1_o,
    input  logic [1:0]         deq_cnt_i,
    output logic [PTR_W:0]     cnt_o
);

    localparam int unsigned      CNT_W = PTR_W + 1;
    localparam logic [INST_DW-1:0] NOP = INST_DW'(32'h0000_0013);

    logic [INST_DW-1:0] inst_q [DEPTH];
    logic [INST_AW-1:0] pc_q   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic             rdy;
    logic             wr0;
    logic             wr1;
    logic [1:0]       push;
    logic [1:0]       req;
    logic [1:0]       pop;

    // Enqueue/dequeue amounts: push only with two free slots, pop clamped to occupancy
    always_comb begin
        rdy     = (count <= CNT_W'(DEPTH - 2));
        wr0     = rdy & in_vld0_i;
        wr1     = wr0 & in_vld1_i;
        push    = wr1 ? 2'd2 : (wr0 ? 2'd1 : 2'd0);
        req     = (deq_cnt_i == 2'd3) ? 2'd2 : deq_cnt_i;
        pop     = (CNT_W'(req) > count) ? count[1:0] : req;
        head_p1 = head + PTR_W'(1);
        tail_p1 = tail + PTR_W'(1);
    end

    // Pointer and occupancy update; reset beats flush beats normal traffic
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop);
            tail  <= tail + PTR_W'(push);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage; slot 0 lands at tail, the younger slot 1 at tail+1
    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            if (wr0) begin
                inst_q[tail] <= in_inst0_i;
                pc_q[tail]   <= in_pc0_i;
            end
            if (wr1) begin
                inst_q[tail_p1] <= in_inst1_i;
                pc_q[tail_p1]   <= in_pc1_i;
            end
        end
    end

    // Decode view of the two oldest entries; invalid slots show a NOP at pc 0
    always_comb begin
        in_rdy_o    = rdy;
        cnt_o       = count;
        out_vld0_o  = (count >= CNT_W'(1));
        out_vld1_o  = (count >= CNT_W'(2));
        out_inst0_o = NOP;
        out_pc0_o   = '0;
        out_inst1_o = NOP;
        out_pc1_o   = '0;
        if (out_vld0_o) begin
            out_inst0_o = inst_q[head];
            out_pc0_o   = pc_q[head];
        end
        if (out_vld1_o) begin
            out_inst1_o = inst_q[head_p1];
            out_pc1_o   = pc_q[head_p1];
        end
    end

endmodule
